// File: rtl/vtc_detect.sv
// vtc_detect: recovers pixel/line coordinates from an incoming hsync/vsync/DE
// stream and measures frame geometry, asserting a lock flag once the measured
// timing repeats unchanged over LOCK_FRAMES consecutive frames.
//
// Ports:
//   i_clk, i_rstn        pixel clock, synchronous active-low reset
//   i_hsync, i_vsync     active-high syncs
//   i_active             data enable
//   o_counterX/Y         recovered coordinates (0 on first active pixel/line)
//   o_frame_start        one-cycle pulse per vsync rising edge
//   o_res_width/height   total clocks per line / lines per frame
//   o_active_x/y         active pixels per line / lines per frame
//   o_hsync_width        hsync pulse width in clocks
//   o_vsync_width        vsync pulse width in lines
//   o_locked             high while the timing is stable
module vtc_detect #(
    parameter int unsigned COUNTER_WIDTH = 12,
    parameter int unsigned LOCK_FRAMES   = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_hsync,
    input  logic                     i_vsync,
    input  logic                     i_active,
    output logic [COUNTER_WIDTH-1:0] o_counterX,
    output logic [COUNTER_WIDTH-1:0] o_counterY,
    output logic                     o_frame_start,
    output logic [COUNTER_WIDTH-1:0] o_res_width,
    output logic [COUNTER_WIDTH-1:0] o_res_height,
    output logic [COUNTER_WIDTH-1:0] o_active_x,
    output logic [COUNTER_WIDTH-1:0] o_active_y,
    output logic [COUNTER_WIDTH-1:0] o_hsync_width,
    output logic [COUNTER_WIDTH-1:0] o_vsync_width,
    output logic                     o_locked
);

    localparam int unsigned    CW      = COUNTER_WIDTH;
    localparam logic [CW-1:0]  One     = CW'(1);
    localparam logic [CW-1:0]  Max     = '1;
    localparam logic [3:0]     LockCnt = 4'(LOCK_FRAMES);

    localparam logic [1:0] StSearch  = 2'd0;
    localparam logic [1:0] StMeasure = 2'd1;
    localparam logic [1:0] StVerify  = 2'd2;
    localparam logic [1:0] StLocked  = 2'd3;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == Max) ? v : v + One;
    endfunction

    // Two-stage input registers; edges are detected between the stages.
    logic hs_s1, hs_s2, vs_s1, vs_s2, de_s1, de_s2;
    logic hs_rise, hs_fall, vs_rise, de_rise, de_fall;

    assign hs_rise = hs_s1 & ~hs_s2;
    assign hs_fall = ~hs_s1 & hs_s2;
    assign vs_rise = vs_s1 & ~vs_s2;
    assign de_rise = de_s1 & ~de_s2;
    assign de_fall = ~de_s1 & de_s2;

    logic          y_pending;
    logic [CW-1:0] h_per, line_width, hs_len, line_hsw, act_len, line_ax;
    logic [CW-1:0] lines, vs_lines, act_lines;
    logic [CW-1:0] cand_lines, cand_vs_lines, cand_act_lines;
    logic [6*CW-1:0] cand, ref_meas;
    logic          cand_ok;
    logic [3:0]    match_cnt, match_nxt;
    logic [1:0]    state;

    // An edge coinciding with the vsync rise still belongs to the closing frame.
    assign cand_lines     = hs_rise ? sat_inc(lines) : lines;
    assign cand_vs_lines  = (hs_rise && vs_s1) ? sat_inc(vs_lines) : vs_lines;
    assign cand_act_lines = de_rise ? sat_inc(act_lines) : act_lines;

    assign cand = {line_width, cand_lines, line_ax, cand_act_lines, line_hsw, cand_vs_lines};
    assign match_nxt = match_cnt + 4'd1;

    always_comb begin
        cand_ok = (cand == ref_meas);
        for (int i = 0; i < 6; i++) begin
            if (cand[i*CW +: CW] == '0) cand_ok = 1'b0;
        end
    end

    assign o_locked = (state == StLocked);

    // Input stage, coordinates and per-line / per-frame counters.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            {hs_s1, hs_s2, vs_s1, vs_s2, de_s1, de_s2} <= '0;
            o_counterX <= '0;
            o_counterY <= '0;
            y_pending  <= 1'b0;
            h_per      <= '0;
            line_width <= '0;
            hs_len     <= '0;
            line_hsw   <= '0;
            act_len    <= '0;
            line_ax    <= '0;
            lines      <= '0;
            vs_lines   <= '0;
            act_lines  <= '0;
        end else begin
            hs_s1 <= i_hsync;
            hs_s2 <= hs_s1;
            vs_s1 <= i_vsync;
            vs_s2 <= vs_s1;
            de_s1 <= i_active;
            de_s2 <= de_s1;

            o_counterX <= de_rise ? '0 : sat_inc(o_counterX);

            if (de_rise) begin
                if (y_pending) begin
                    o_counterY <= '0;
                    y_pending  <= 1'b0;
                end else begin
                    o_counterY <= sat_inc(o_counterY);
                end
            end
            if (vs_rise) y_pending <= 1'b1;

            if (hs_rise) begin
                line_width <= h_per;
                h_per      <= One;
            end else begin
                h_per <= sat_inc(h_per);
            end

            if (hs_rise)    hs_len <= One;
            else if (hs_s1) hs_len <= sat_inc(hs_len);
            if (hs_fall)    line_hsw <= hs_len;

            if (de_rise)    act_len <= One;
            else if (de_s1) act_len <= sat_inc(act_len);
            if (de_fall)    line_ax <= act_len;

            if (vs_rise) begin
                lines     <= '0;
                vs_lines  <= '0;
                act_lines <= '0;
            end else begin
                lines     <= cand_lines;
                vs_lines  <= cand_vs_lines;
                act_lines <= cand_act_lines;
            end
        end
    end

    // Lock FSM and published measurements.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state         <= StSearch;
            ref_meas      <= '0;
            match_cnt     <= '0;
            o_frame_start <= 1'b0;
            {o_res_width, o_res_height, o_active_x, o_active_y,
             o_hsync_width, o_vsync_width} <= '0;
        end else begin
            o_frame_start <= vs_rise;
            if (h_per == Max) begin
                // Line period overflow: hsync is gone, restart acquisition.
                state <= StSearch;
            end else if (vs_rise) begin
                case (state)
                    StSearch: begin
                        state <= StMeasure;
                    end
                    StMeasure: begin
                        ref_meas  <= cand;
                        match_cnt <= '0;
                        state     <= StVerify;
                        {o_res_width, o_res_height, o_active_x, o_active_y,
                         o_hsync_width, o_vsync_width} <= cand;
                    end
                    StVerify: begin
                        {o_res_width, o_res_height, o_active_x, o_active_y,
                         o_hsync_width, o_vsync_width} <= cand;
                        if (cand_ok) begin
                            match_cnt <= match_nxt;
                            if (match_nxt == LockCnt) state <= StLocked;
                        end else begin
                            ref_meas  <= cand;
                            match_cnt <= '0;
                        end
                    end
                    StLocked: begin
                        {o_res_width, o_res_height, o_active_x, o_active_y,
                         o_hsync_width, o_vsync_width} <= cand;
                        if (!cand_ok) begin
                            ref_meas  <= cand;
                            match_cnt <= '0;
                            state     <= StVerify;
                        end
                    end
                    default: state <= StSearch;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vtc_detect.sv
// Scoreboard bench for vtc_detect. Frames are generated with vsync occupying
// the first lines so each vsync rise closes exactly one generated frame. The
// timings are scaled-down versions of 640x480 and 720p to keep runs short.
module tb_vtc_detect;

    localparam int CW = 12;

    typedef struct {
        int htot; int hact; int hs_start; int hs_len;
        int vtot; int vact; int va_start; int vs_len;
    } tim_t;

    typedef struct { int w; int h; int ax; int ay; int hsw; int vsw; } meas_t;

    typedef struct { longint due; meas_t m; bit lk; } fexp_t;

    // kind: 0 counterX, 1 counterY, 2 locked, 3 all outputs zero
    typedef struct { longint due; int kind; int val; } texp_t;

    logic clk, i_rstn, i_hsync, i_vsync, i_active;
    logic [CW-1:0] o_counterX, o_counterY, o_res_width, o_res_height;
    logic [CW-1:0] o_active_x, o_active_y, o_hsync_width, o_vsync_width;
    logic o_frame_start, o_locked;

    vtc_detect #(.COUNTER_WIDTH(CW), .LOCK_FRAMES(4)) dut (
        .i_clk        (clk),
        .i_rstn       (i_rstn),
        .i_hsync      (i_hsync),
        .i_vsync      (i_vsync),
        .i_active     (i_active),
        .o_counterX   (o_counterX),
        .o_counterY   (o_counterY),
        .o_frame_start(o_frame_start),
        .o_res_width  (o_res_width),
        .o_res_height (o_res_height),
        .o_active_x   (o_active_x),
        .o_active_y   (o_active_y),
        .o_hsync_width(o_hsync_width),
        .o_vsync_width(o_vsync_width),
        .o_locked     (o_locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int     n_vec  = 0;
    int     n_fail = 0;
    fexp_t  fq[$];
    texp_t  tq[$];
    longint last_hs = 0;

    task automatic chk(input string nm, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, got, exp);
        end
    endtask

    // Monitor: frame-start scoreboard plus cycle-stamped point checks.
    always @(negedge clk) begin
        fexp_t e;
        if (o_frame_start === 1'b1 || (fq.size() > 0 && fq[0].due == cyc)) begin
            if (fq.size() == 0) begin
                chk("unexpected_frame_start", 1, 0);
            end else begin
                e = fq.pop_front();
                chk("frame_start", o_frame_start, 1);
                chk("frame_start_cycle", cyc, e.due);
                chk("res_width", o_res_width, e.m.w);
                chk("res_height", o_res_height, e.m.h);
                chk("active_x", o_active_x, e.m.ax);
                chk("active_y", o_active_y, e.m.ay);
                chk("hsync_width", o_hsync_width, e.m.hsw);
                chk("vsync_width", o_vsync_width, e.m.vsw);
                chk("locked", o_locked, e.lk);
            end
        end
        for (int i = tq.size() - 1; i >= 0; i--) begin
            if (tq[i].due == cyc) begin
                case (tq[i].kind)
                    0: chk("counterX", o_counterX, tq[i].val);
                    1: chk("counterY", o_counterY, tq[i].val);
                    2: chk("locked_point", o_locked, tq[i].val);
                    default: chk("reset_outputs_zero",
                                 {o_counterX, o_counterY, o_frame_start, o_res_width,
                                  o_res_height, o_active_x, o_active_y, o_hsync_width,
                                  o_vsync_width, o_locked} == '0, 1);
                endcase
                tq.delete(i);
            end
        end
    end

    task automatic push_t(input longint due, input int kind, input int val);
        texp_t t;
        t.due = due; t.kind = kind; t.val = val;
        tq.push_back(t);
    endtask

    task automatic gen_frame(input tim_t t, input meas_t m, input bit lk,
                             input int rst_line, input bit coord);
        fexp_t e;
        bit hs, vs, de;
        for (int l = 0; l < t.vtot; l++) begin
            for (int x = 0; x < t.htot; x++) begin
                hs = (x >= t.hs_start) && (x < t.hs_start + t.hs_len);
                vs = (l < t.vs_len);
                de = (l >= t.va_start) && (l < t.va_start + t.vact) && (x < t.hact);
                @(negedge clk);
                i_hsync  = hs;
                i_vsync  = vs;
                i_active = de;
                i_rstn   = !(l == rst_line && x == 0);
                if (l == 0 && x == 0) begin
                    e.due = cyc + 2; e.m = m; e.lk = lk;
                    fq.push_back(e);
                end
                if (!i_rstn) push_t(cyc + 1, 3, 0);
                if (x == t.hs_start) last_hs = cyc;
                if (coord && de) begin
                    if (l == t.va_start && x == 0) begin
                        push_t(cyc + 2, 0, 0);
                        push_t(cyc + 2, 1, 0);
                    end
                    if (l == t.va_start + 2 && x == 5) begin
                        push_t(cyc + 2, 0, 5);
                        push_t(cyc + 2, 1, 2);
                    end
                    if (l == t.va_start + t.vact - 1 && x == t.hact - 1) begin
                        push_t(cyc + 2, 0, t.hact - 1);
                        push_t(cyc + 2, 1, t.vact - 1);
                    end
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            {i_hsync, i_vsync, i_active} = 3'b000;
            i_rstn = 1'b1;
        end
    endtask

    initial begin
        tim_t  ta, ta21, tb;
        meas_t ma, ma21, mb, mz;
        ta   = '{htot: 20, hact: 12, hs_start: 14, hs_len: 4,
                 vtot: 12, vact: 8,  va_start: 3,  vs_len: 2};
        ta21 = ta;
        ta21.htot = 21;
        tb   = '{htot: 33, hact: 26, hs_start: 28, hs_len: 3,
                 vtot: 20, vact: 12, va_start: 7,  vs_len: 5};
        ma   = '{20, 12, 12, 8, 4, 2};
        ma21 = '{21, 12, 12, 8, 4, 2};
        mb   = '{33, 20, 26, 12, 3, 5};
        mz   = '{0, 0, 0, 0, 0, 0};

        i_rstn = 1'b0;
        {i_hsync, i_vsync, i_active} = 3'b000;
        repeat (3) @(negedge clk);
        push_t(cyc + 1, 3, 0);
        @(negedge clk);
        i_rstn = 1'b1;

        // Acquire and lock; frame 9 has a 21-clock line total.
        gen_frame(ta, mz, 0, -1, 1);
        for (int f = 2; f <= 5; f++) gen_frame(ta, ma, 0, -1, 1);
        for (int f = 6; f <= 8; f++) gen_frame(ta, ma, 1, -1, 1);
        gen_frame(ta21, ma, 1, -1, 1);
        gen_frame(ta, ma21, 0, -1, 1);
        for (int f = 11; f <= 14; f++) gen_frame(ta, ma, 0, -1, 1);
        gen_frame(ta, ma, 1, -1, 1);
        gen_frame(ta, ma, 1, -1, 1);

        // Sync loss: lock must drop exactly one cycle after h_per saturates.
        push_t(last_hs + 4096, 2, 1);
        push_t(last_hs + 4097, 2, 0);
        idle(4100);
        for (int x = 0; x < ta.htot; x++) begin
            @(negedge clk);
            i_hsync = (x >= ta.hs_start) && (x < ta.hs_start + ta.hs_len);
        end
        for (int f = 17; f <= 21; f++) gen_frame(ta, ma, 0, -1, 1);
        gen_frame(ta, ma, 1, -1, 1);

        // One-cycle reset mid-frame, then reacquire from scratch.
        gen_frame(ta, ma, 1, 5, 0);
        gen_frame(ta, mz, 0, -1, 1);
        for (int f = 25; f <= 28; f++) gen_frame(ta, ma, 0, -1, 1);
        gen_frame(ta, ma, 1, -1, 1);

        // Switch to the 720p-shaped timing.
        gen_frame(tb, ma, 1, -1, 1);
        for (int f = 31; f <= 34; f++) gen_frame(tb, mb, 0, -1, 1);
        gen_frame(tb, mb, 1, -1, 1);

        idle(10);
        chk("frame_queue_drained", fq.size(), 0);
        chk("point_queue_drained", tq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
